// File: rtl/rvm_shift_arb.sv
// rvm_shift_arb: shares one combinational rvm_shift unit between two requesters.
// Define RVM_SHIFT_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module rvm_shift_arb (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [1:0]  req0_op,
    input  logic [31:0] req0_lhs,
    input  logic [4:0]  req0_rhs,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [1:0]  req1_op,
    input  logic [31:0] req1_lhs,
    input  logic [4:0]  req1_rhs,

    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,

    output logic [1:0]  sh_op,
    output logic [31:0] sh_lhs,
    output logic [4:0]  sh_rhs,
    input  logic        sh_valid,
    input  logic [31:0] sh_result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] lhs_q, lhs_d;
    logic [4:0]  rhs_q, rhs_d;
    logic [31:0] result_q, result_d;

    logic        any_req;
    logic        win;
    logic        owner_rsp_ready;

    // Arbitration: win = 1 selects port 1.
    always_comb begin
        any_req = req0_valid | req1_valid;
`ifdef RVM_SHIFT_ARB_RR_EN
        if (req0_valid && req1_valid) begin
            win = ~last_q;
        end else begin
            win = req1_valid;
        end
`else
        win = ~req0_valid & req1_valid;
`endif
    end

    assign owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        op_d       = op_q;
        lhs_d      = lhs_q;
        rhs_d      = rhs_q;
        result_d   = result_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        rsp0_valid = 1'b0;
        rsp1_valid = 1'b0;
        sh_op      = 2'b00;
        sh_lhs     = '0;
        sh_rhs     = '0;

        unique case (state_q)
            IDLE: begin
                req0_ready = any_req & ~win;
                req1_ready = any_req & win;
                if (any_req) begin
                    op_d    = win ? req1_op  : req0_op;
                    lhs_d   = win ? req1_lhs : req0_lhs;
                    rhs_d   = win ? req1_rhs : req0_rhs;
                    owner_d = win;
                    last_d  = win;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                sh_op    = op_q;
                sh_lhs   = lhs_q;
                sh_rhs   = rhs_q;
                // A NOP issue yields zero regardless of what the unit drives.
                result_d = sh_valid ? sh_result : '0;
                state_d  = RESP;
            end
            RESP: begin
                rsp0_valid = ~owner_q;
                rsp1_valid = owner_q;
                if (owner_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            op_q     <= 2'b00;
            lhs_q    <= '0;
            rhs_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            op_q     <= op_d;
            lhs_q    <= lhs_d;
            rhs_q    <= rhs_d;
            result_q <= result_d;
        end
    end

    assign rsp_result = result_q;

endmodule

// File: tb/tb_rvm_shift_arb.sv
// tb_rvm_shift_arb: directed bench for rvm_shift_arb with a response scoreboard.
// The bench models the shared shifter unit on the sh_* side.
module tb_rvm_shift_arb;

    logic        g_clk;
    logic        g_resetn;
    logic        req0_valid, req0_ready;
    logic [1:0]  req0_op;
    logic [31:0] req0_lhs;
    logic [4:0]  req0_rhs;
    logic        req1_valid, req1_ready;
    logic [1:0]  req1_op;
    logic [31:0] req1_lhs;
    logic [4:0]  req1_rhs;
    logic        rsp0_valid, rsp0_ready;
    logic        rsp1_valid, rsp1_ready;
    logic [31:0] rsp_result;
    logic [1:0]  sh_op;
    logic [31:0] sh_lhs;
    logic [4:0]  sh_rhs;
    logic        sh_valid;
    logic [31:0] sh_result;

    typedef struct {
        bit          port;
        logic [31:0] res;
    } exp_t;

    exp_t sb[$];
    int   total;
    int   passed;

    rvm_shift_arb dut (
        .g_clk      (g_clk),
        .g_resetn   (g_resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_lhs   (req0_lhs),
        .req0_rhs   (req0_rhs),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_lhs   (req1_lhs),
        .req1_rhs   (req1_rhs),
        .rsp0_valid (rsp0_valid),
        .rsp0_ready (rsp0_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_ready (rsp1_ready),
        .rsp_result (rsp_result),
        .sh_op      (sh_op),
        .sh_lhs     (sh_lhs),
        .sh_rhs     (sh_rhs),
        .sh_valid   (sh_valid),
        .sh_result  (sh_result)
    );

    initial g_clk = 1'b0;
    always #5 g_clk = ~g_clk;

    // Shared shifter unit model.
    always_comb begin
        sh_valid = (sh_op != 2'b00);
        case (sh_op)
            2'b01:   sh_result = sh_lhs << sh_rhs;
            2'b10:   sh_result = sh_lhs >> sh_rhs;
            2'b11:   sh_result = $unsigned($signed(sh_lhs) >>> sh_rhs);
            default: sh_result = 32'h0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic rdy(input bit p);
        return p ? req1_ready : req0_ready;
    endfunction

    function automatic logic rspv(input bit p);
        return p ? rsp1_valid : rsp0_valid;
    endfunction

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    // Response monitor: every completed response must match the scoreboard head.
    always @(negedge g_clk) begin
        if (g_resetn) begin
            if (rsp0_valid && rsp1_valid) begin
                chk("both_rsp_valid", 32'd1, 32'd0);
            end
            if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_port", {31'd0, rsp1_valid}, {31'd0, e.port});
                    chk("sb_result", rsp_result, e.res);
                end
            end
        end
    end

    // Starts at posedge+1 in IDLE; returns at posedge+1 of the EXEC cycle.
    task automatic send(input bit p, input logic [1:0] op,
                        input logic [31:0] l, input logic [4:0] r,
                        input logic [31:0] exp);
        int n;
        exp_t e;
        if (p) begin
            req1_valid = 1'b1; req1_op = op; req1_lhs = l; req1_rhs = r;
        end else begin
            req0_valid = 1'b1; req0_op = op; req0_lhs = l; req0_rhs = r;
        end
        #1;
        n = 0;
        while (!rdy(p) && n < 20) begin
            tick();
            n++;
        end
        chk("grant", {31'd0, rdy(p)}, 32'd1);
        chk("sh_op_idle", {30'd0, sh_op}, 32'd0);
        e.port = p;
        e.res  = exp;
        sb.push_back(e);
        tick();
        if (p) req1_valid = 1'b0;
        else   req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input bit p, input logic [31:0] exp);
        int n;
        n = 0;
        while (!rspv(p) && n < 10) begin
            tick();
            n++;
        end
        chk("rsp_valid", {31'd0, rspv(p)}, 32'd1);
        chk("rsp_result", rsp_result, exp);
        tick();
    endtask

    logic [31:0] gexp[4];
    logic [31:0] gobs;

    initial begin
        int ng;
        int n;
        exp_t e;
        total = 0;
        passed = 0;
        g_resetn = 1'b0;
        req0_valid = 1'b0; req0_op = 2'b00; req0_lhs = '0; req0_rhs = '0;
        req1_valid = 1'b0; req1_op = 2'b00; req1_lhs = '0; req1_rhs = '0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        tick();
        tick();
        g_resetn = 1'b1;
        #1;

        chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_sh_op", {30'd0, sh_op}, 32'd0);
        chk("rst_sh_lhs", sh_lhs, 32'd0);
        chk("rst_result", rsp_result, 32'd0);
        tick();

        // Single SLL with exact cycle timing.
        send(1'b0, 2'b01, 32'h0000_0001, 5'd31, 32'h8000_0000);
        chk("sll_exec_op", {30'd0, sh_op}, 32'd1);
        chk("sll_exec_lhs", sh_lhs, 32'h1);
        chk("sll_exec_rhs", {27'd0, sh_rhs}, 32'd31);
        tick();
        chk("sll_resp_v0", {31'd0, rsp0_valid}, 32'd1);
        chk("sll_resp_v1", {31'd0, rsp1_valid}, 32'd0);
        chk("sll_resp_res", rsp_result, 32'h8000_0000);
        chk("sll_resp_op", {30'd0, sh_op}, 32'd0);
        tick();
        chk("sll_idle_v0", {31'd0, rsp0_valid}, 32'd0);

        // SRA sign fill then SRL zero fill on port 1.
        send(1'b1, 2'b11, 32'h8000_0000, 5'd4, 32'hF800_0000);
        wait_rsp(1'b1, 32'hF800_0000);
        send(1'b1, 2'b10, 32'h8000_0000, 5'd4, 32'h0800_0000);
        wait_rsp(1'b1, 32'h0800_0000);

        // Response backpressure on port 0 while port 1 waits.
        rsp0_ready = 1'b0;
        send(1'b0, 2'b01, 32'h3, 5'd2, 32'hC);
        req1_valid = 1'b1; req1_op = 2'b11;
        req1_lhs = 32'hF000_0000; req1_rhs = 5'd4;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
            chk("bp_result", rsp_result, 32'hC);
            chk("bp_req1_ready", {31'd0, req1_ready}, 32'd0);
            tick();
        end
        rsp0_ready = 1'b1;
        #1;
        chk("bp_release_req1", {31'd0, req1_ready}, 32'd0);
        tick();
        chk("bp_idle_grant1", {31'd0, req1_ready}, 32'd1);
        e.port = 1'b1;
        e.res  = 32'hFF00_0000;
        sb.push_back(e);
        tick();
        req1_valid = 1'b0;
        wait_rsp(1'b1, 32'hFF00_0000);

        // NOP request.
        send(1'b0, 2'b00, 32'hDEAD_BEEF, 5'd7, 32'h0);
        chk("nop_exec_op", {30'd0, sh_op}, 32'd0);
        wait_rsp(1'b0, 32'h0);

        // Reset while in RESP.
        rsp0_ready = 1'b0;
        send(1'b0, 2'b01, 32'h1, 5'd4, 32'h10);
        tick();
        chk("rr_resp_v0", {31'd0, rsp0_valid}, 32'd1);
        sb.delete();
        g_resetn = 1'b0;
        tick();
        g_resetn = 1'b1;
        rsp0_ready = 1'b1;
        chk("rr_after_v0", {31'd0, rsp0_valid}, 32'd0);
        chk("rr_after_res", rsp_result, 32'd0);
        req0_valid = 1'b1;
        #1;
        chk("rr_idle_ready", {31'd0, req0_ready}, 32'd1);
        req0_valid = 1'b0;
        send(1'b0, 2'b10, 32'h100, 5'd4, 32'h10);
        wait_rsp(1'b0, 32'h10);

        // Contention from a fresh reset.
        g_resetn = 1'b0;
        tick();
        tick();
        g_resetn = 1'b1;
`ifdef RVM_SHIFT_ARB_RR_EN
        gexp = '{32'd0, 32'd1, 32'd0, 32'd1};
`else
        gexp = '{32'd0, 32'd0, 32'd0, 32'd0};
`endif
        req0_valid = 1'b1; req0_op = 2'b01; req0_lhs = 32'h1; req0_rhs = 5'd3;
        req1_valid = 1'b1; req1_op = 2'b10;
        req1_lhs = 32'h8000_0000; req1_rhs = 5'd4;
        ng = 0;
        n = 0;
        while (ng < 4 && n < 40) begin
            #1;
            if (req0_ready || req1_ready) begin
                gobs = {31'd0, req1_ready};
                chk("contention_grant", gobs, gexp[ng]);
                e.port = req1_ready;
                e.res  = req1_ready ? 32'h0800_0000 : 32'h8;
                sb.push_back(e);
                ng++;
            end
            tick();
            n++;
        end
        chk("contention_count", ng, 32'd4);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (5) tick();
        chk("sb_drained", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/rvm_shift_arb.md
# rvm_shift_arb

Controller that shares the single combinational `rvm_shift` unit between two requesters: port 0, the execute-stage ALU path, and port 1, the load/store byte-alignment path. It arbitrates between the requesters and registers the selected operands. It drives the shifter for exactly one cycle, captures the result and returns it over a valid/ready response channel to the winning requester. Outside that issue cycle the shifter sees op NOP, so its inputs stay isolated.

## Interface
- Parameters: none. Data is fixed at 32 bits and the shift amount at 5 bits.
- `g_clk` in 1: clock, all state on rising edge.
- `g_resetn` in 1: synchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: requester has a shift pending.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle.
- `req0_op` / `req1_op` in 2: shift op (00 NOP, 01 SLL, 10 SRL, 11 SRA).
- `req0_lhs` / `req1_lhs` in 32: value to shift.
- `req0_rhs` / `req1_rhs` in 5: shift amount.
- `rsp0_valid` / `rsp1_valid` out 1: result available for that port.
- `rsp0_ready` / `rsp1_ready` in 1: requester consumes the result.
- `rsp_result` out 32: registered result, shared by both response ports.
- `sh_op` out 2: to shifter `op`.
- `sh_lhs` out 32: to shifter `lhs`.
- `sh_rhs` out 5: to shifter `rhs`.
- `sh_valid` in 1: from shifter `valid`.
- `sh_result` in 32: from shifter `result`.

## Operation
- FSM states are IDLE, EXEC and RESP. Registers are `state`, `owner` (1 bit), `last_grant` (1 bit), `op_r`, `lhs_r`, `rhs_r` and `result_r`.
- IDLE:
  - The arbiter picks a winner among the asserting `reqN_valid`.
  - `reqN_ready` is asserted combinationally for the winner only.
  - On handshake: latch op/lhs/rhs, set `owner` and `last_grant` to the winner, go to EXEC.
  - With no request, stay in IDLE.
- EXEC:
  - `sh_op` = `op_r`, `sh_lhs` = `lhs_r`, `sh_rhs` = `rhs_r`.
  - Capture `sh_result` into `result_r` and go to RESP.
  - A NOP request is legal: the shifter returns 0, `result_r` becomes 0, and the response still completes.
- RESP:
  - `rsp<owner>_valid` = 1. The other response valid stays 0.
  - Hold the state until `rsp<owner>_ready` is 1, then go to IDLE.
  - `rsp_result` stays stable while valid and not ready.
- Outside EXEC, `sh_op` = 00 and `sh_lhs`/`sh_rhs` = 0.
- `sh_valid` is informational: it equals (`op_r` != 00) during EXEC and is not used to stall.
- No request is accepted outside IDLE. Both `reqN_ready` are 0 in EXEC and RESP.

## Timing
- Handshake at cycle T puts the FSM in EXEC during T+1.
- `rspN_valid` rises at T+2.
- If `rsp_ready` is high at T+2, the FSM is back in IDLE at T+3. Peak throughput is one shift per 3 cycles.
- Reset values:
  - `state` = IDLE, `owner` = 0, `last_grant` = 1, `op_r` = 0, `lhs_r` = 0, `rhs_r` = 0, `result_r` = 0.
  - All `*_ready`/`*_valid` outputs = 0, `sh_op` = 00.
- Reset asserted in EXEC or RESP aborts the operation. The following cycle is IDLE with both `rspN_valid` = 0; the in-flight result is discarded.
- Request valids may drop before acceptance without penalty. Nothing is latched unless valid and ready are both high in the same cycle.
- A requester whose response is pending may assert its request again. That request is only considered once the FSM has returned to IDLE.

## Configuration
- `RVM_SHIFT_ARB_RR_EN` defined: round-robin arbitration.
  - On contention the grant goes to the port that is not `last_grant`.
  - After reset, port 0 wins the first contention.
- `RVM_SHIFT_ARB_RR_EN` undefined: fixed priority, port 0 always wins on contention.
  - `last_grant` is still maintained but does not affect the grant.
- With a single requester, both builds grant that requester.

## Test plan
- Single SLL: port 0 sends op 01, lhs 0x0000_0001, rhs 31 at T. Required: `sh_op` = 01 only at T+1; `rsp0_valid` at T+2 with `rsp_result` = 0x8000_0000; `rsp1_valid` stays 0.
- SRA sign fill: port 1 sends op 11, lhs 0x8000_0000, rhs 4. Required: `rsp1_valid` with `rsp_result` = 0xF800_0000. A follow-up SRL with the same operands returns 0x0800_0000.
- Contention, round-robin build: both ports hold valid continuously for 4 transactions. Required: grants in order 0, 1, 0, 1. In the fixed-priority build all 4 grants go to port 0 while its valid stays high.
- Response backpressure: hold `rsp0_ready` = 0 for 5 cycles while port 1 requests. Required: `rsp0_valid` and `rsp_result` stay stable, `req1_ready` stays 0, and port 1 is granted the cycle after IDLE is re-entered.
- NOP request: op 00, lhs 0xDEAD_BEEF. Required: `sh_op` stays 00 throughout and the response arrives with `rsp_result` = 0.
- Reset mid-operation: pull `g_resetn` low in RESP. Required: next cycle has `rsp0_valid` = 0, state IDLE and `result_r` = 0. The next request then completes normally.
